lsu_dmem: RTL

Data-memory responder for the load/store pipe. Accepts one `lsu_pkt_t` request per cycle from the LSU, commits stores to an internal word-organized RAM, and returns a load-data or store-acknowledge response after a fixed, parameterized latency. It sits between the LSU stage of `PIPE_LSU` and the writeback path. Load results are already byte/half extracted and sign/zero extended, ready for writeback.

---
 rtl/srv_defs.sv | 35 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_dmem.sv | 113 +++++++++++
 3 files changed

// File: rtl/srv_defs.sv
// Shared load/store definitions: opcode encoding, request packet and response word.
package srv_defs;

    localparam int XLEN = 32;

    // opc[3] selects store; opc[2:0] is the RISC-V funct3
    typedef enum logic [3:0] {
        LSU_LB  = 4'b0000,
        LSU_LH  = 4'b0001,
        LSU_LW  = 4'b0010,
        LSU_LBU = 4'b0100,
        LSU_LHU = 4'b0101,
        LSU_SB  = 4'b1000,
        LSU_SH  = 4'b1001,
        LSU_SW  = 4'b1010
    } lsu_opc_t;

    typedef struct packed {
        logic            valid;
        lsu_opc_t        opc;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_pkt_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] data;
        logic            err;
    } lsu_rsp_t;

    function automatic logic opc_is_store(input logic [3:0] opc);
        return opc[3];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational size/alignment logic: request legality, store lane placement,
// and extract-and-extend of a read word for loads.
module lsu_align
    import srv_defs::*;
(
    input  logic [3:0]  opc_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        err_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [3:0]  ld_opc_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request side; anything not listed is an illegal opcode and errors out
    always_comb begin
        err_o   = 1'b1;
        be_o    = 4'b0000;
        wdata_o = '0;
        case (opc_i)
            LSU_LB, LSU_LBU: err_o = 1'b0;
            LSU_LH, LSU_LHU: err_o = addr_i[0];
            LSU_LW:          err_o = |addr_i;
            LSU_SB: begin
                err_o   = 1'b0;
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_SH: begin
                err_o   = addr_i[0];
                be_o    = addr_i[0] ? 4'b0000 : (addr_i[1] ? 4'b1100 : 4'b0011);
                wdata_o = {2{wdata_i[15:0]}};
            end
            LSU_SW: begin
                err_o   = |addr_i;
                be_o    = (|addr_i) ? 4'b0000 : 4'b1111;
                wdata_o = wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = rdata_i[{ld_addr_i, 3'b000} +: 8];
        ld_half   = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = '0;
        case (ld_opc_i)
            LSU_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LSU_LBU: ld_data_o = {24'b0, ld_byte};
            LSU_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            LSU_LHU: ld_data_o = {16'b0, ld_half};
            LSU_LW:  ld_data_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_dmem.sv
// Data-memory responder: word RAM with byte-lane stores and a fixed-latency,
// in-order response pipeline carrying extended load data or errors.
module lsu_dmem
    import srv_defs::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  lsu_pkt_t    req_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic          acc;
    logic          req_err;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          we;
    logic          unused_addr;

    logic [31:0]   rdata_q;
    logic          s1_vld_q;
    logic          s1_err_q;
    logic [3:0]    s1_opc_q;
    logic [1:0]    s1_addr_q;
    logic [31:0]   s1_ld_data;
    lsu_rsp_t      s1_rsp;
    lsu_rsp_t      rsp_out;

    assign idx         = req_i.addr[AW+1:2];
    assign unused_addr = ^req_i.addr[31:AW+2];
    assign acc         = req_i.valid && !rst_i;
    assign we          = acc && opc_is_store(req_i.opc) && !req_err;

    lsu_align u_align (
        .opc_i     (req_i.opc),
        .addr_i    (req_i.addr[1:0]),
        .wdata_i   (req_i.wdata),
        .err_o     (req_err),
        .be_o      (req_be),
        .wdata_o   (req_wdata),
        .ld_opc_i  (s1_opc_q),
        .ld_addr_i (s1_addr_q),
        .rdata_i   (rdata_q),
        .ld_data_o (s1_ld_data)
    );

    // RAM is not reset; a load in the next cycle sees this write
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) rdata_q <= mem_q[idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_opc_q  <= '0;
            s1_addr_q <= '0;
        end else begin
            s1_vld_q <= acc;
            if (acc) begin
                s1_err_q  <= req_err;
                s1_opc_q  <= req_i.opc;
                s1_addr_q <= req_i.addr[1:0];
            end
        end
    end

    // Data and err are forced to zero unless a response is present
    always_comb begin
        s1_rsp       = '0;
        s1_rsp.valid = s1_vld_q;
        s1_rsp.err   = s1_vld_q && s1_err_q;
        if (s1_vld_q && !s1_err_q && !opc_is_store(s1_opc_q)) s1_rsp.data = s1_ld_data;
    end

    if (LATENCY == 1) begin : g_lat1
        assign rsp_out = s1_rsp;
    end else begin : g_pipe
        lsu_rsp_t pipe_q [2:LATENCY];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 2; i <= LATENCY; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[2] <= s1_rsp;
                for (int i = 3; i <= LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign rsp_out = pipe_q[LATENCY];
    end

    assign rsp_valid_o = rsp_out.valid;
    assign rsp_data_o  = rsp_out.data;
    assign rsp_err_o   = rsp_out.err;

endmodule
